// File: rtl/fle_acc_pkg.sv
// Shared encodings for the fle carry-chain accumulator slice:
// op codes, buffer FSM states and legal WIDTH range.
package fle_acc_pkg;

    typedef enum logic [1:0] {
        ACC_OP_ADD   = 2'b00,
        ACC_OP_LOAD  = 2'b01,
        ACC_OP_CLEAR = 2'b10,
        ACC_OP_HOLD  = 2'b11
    } acc_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } acc_state_e;

    localparam int ACC_WIDTH_MIN = 1;
    localparam int ACC_WIDTH_MAX = 32;

endpackage

// File: rtl/fle_carry_chain_accumulator_if.sv
// Operand/result handshake bundle for the carry-chain accumulator.
// master = upstream/downstream environment, slave = accumulator stage.
interface fle_carry_chain_accumulator_if #(
    parameter int WIDTH = 4
);
    logic             acc_in_valid;
    logic             acc_in_ready;
    logic [WIDTH-1:0] acc_in_data;
    logic [1:0]       acc_in_op;
    logic             acc_in_cin;
    logic             acc_out_valid;
    logic             acc_out_ready;
    logic [WIDTH-1:0] acc_out_sum;
    logic             acc_out_cout;
    logic             acc_overflow;
    logic             acc_ovf_clr;

    modport master (
        output acc_in_valid, acc_in_data, acc_in_op, acc_in_cin,
        output acc_out_ready, acc_ovf_clr,
        input  acc_in_ready, acc_out_valid, acc_out_sum,
        input  acc_out_cout, acc_overflow
    );

    modport slave (
        input  acc_in_valid, acc_in_data, acc_in_op, acc_in_cin,
        input  acc_out_ready, acc_ovf_clr,
        output acc_in_ready, acc_out_valid, acc_out_sum,
        output acc_out_cout, acc_overflow
    );

endinterface

// File: rtl/fle_ripple_chain.sv
// Stateless ripple of WIDTH single-bit full-add cells.
// Cell 0 takes cin_i; cell i takes the carry of cell i-1.
module fle_ripple_chain #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        assign p          = a_i[i] ^ b_i[i];
        assign sum_o[i]   = p ^ carry[i];
        assign carry[i+1] = (a_i[i] & b_i[i]) | (p & carry[i]);
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/fle_carry_chain_accumulator.sv
// Registered accumulate stage behind the fle adder chain, with a
// single-entry result buffer and sticky carry-out overflow flag.
module fle_carry_chain_accumulator
    import fle_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input logic clk,
    input logic reset,
    fle_carry_chain_accumulator_if.slave bus
);

    if (WIDTH < ACC_WIDTH_MIN || WIDTH > ACC_WIDTH_MAX) begin : g_bad_width
        $error("fle_carry_chain_accumulator: WIDTH out of range");
    end

    acc_state_e       state_q;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cout_q, cout_d;
    logic             ovf_q;
    logic [WIDTH-1:0] chain_sum;
    logic             chain_cout;
    logic             accept;
    logic             in_ready;

    fle_ripple_chain #(.WIDTH(WIDTH)) u_chain (
        .a_i    (acc_q),
        .b_i    (bus.acc_in_data),
        .cin_i  (bus.acc_in_cin),
        .sum_o  (chain_sum),
        .cout_o (chain_cout)
    );

    // Drain and refill of the single buffer entry may share a cycle.
    assign in_ready = (state_q == ST_EMPTY) || bus.acc_out_ready;
    assign accept   = bus.acc_in_valid && in_ready;

    always_comb begin
        acc_d  = acc_q;
        cout_d = 1'b0;
        unique case (bus.acc_in_op)
            ACC_OP_ADD: begin
                acc_d  = chain_sum;
                cout_d = chain_cout;
            end
            ACC_OP_LOAD:  acc_d = bus.acc_in_data;
            ACC_OP_CLEAR: acc_d = '0;
            ACC_OP_HOLD:  acc_d = acc_q;
        endcase
    end

    // The buffered sum always equals the running accumulator,
    // so one register serves both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            acc_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            state_q <= ST_FULL;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
        end else if (bus.acc_out_ready) begin
            state_q <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (accept && bus.acc_in_op == ACC_OP_ADD && chain_cout) begin
            ovf_q <= 1'b1;
        end else if (bus.acc_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.acc_in_ready  = in_ready;
    assign bus.acc_out_valid = (state_q == ST_FULL);
    assign bus.acc_out_sum   = acc_q;
    assign bus.acc_out_cout  = cout_q;
    assign bus.acc_overflow  = ovf_q;

endmodule

// File: tb/tb_fle_carry_chain_accumulator.sv
// Randomised self-checking bench for fle_carry_chain_accumulator
// against an arithmetic reference model (WIDTH=4, modulo 16).
module tb_fle_carry_chain_accumulator;

    localparam int W = 4;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [W-1:0] m_acc;
    logic         m_cout;
    logic         m_ovf;

    fle_carry_chain_accumulator_if #(.WIDTH(W)) bus ();

    fle_carry_chain_accumulator #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+2:0] snap();
        return {bus.acc_out_valid, bus.acc_out_cout,
                bus.acc_overflow, bus.acc_out_sum};
    endfunction

    function automatic logic [W+2:0] expv(input logic v);
        return {v, m_cout, m_ovf, m_acc};
    endfunction

    // One accepted operation with downstream ready, plus model update.
    task automatic send(input logic [1:0] op, input logic [W-1:0] d,
                        input logic cin, input logic clr);
        logic [W:0] full;
        bus.acc_in_valid  = 1'b1;
        bus.acc_in_op     = op;
        bus.acc_in_data   = d;
        bus.acc_in_cin    = cin;
        bus.acc_out_ready = 1'b1;
        bus.acc_ovf_clr   = clr;
        @(posedge clk);
        #1;
        bus.acc_in_valid = 1'b0;
        bus.acc_ovf_clr  = 1'b0;
        full = {1'b0, m_acc} + {1'b0, d} + (W+1)'(cin);
        m_cout = 1'b0;
        case (op)
            2'b00: begin
                m_acc  = full[W-1:0];
                m_cout = full[W];
                if (full[W]) m_ovf = 1'b1;
                else if (clr) m_ovf = 1'b0;
            end
            2'b01: m_acc = d;
            2'b10: m_acc = '0;
            default: ;
        endcase
        if (op != 2'b00 && clr) m_ovf = 1'b0;
    endtask

    task automatic idle(input logic clr);
        bus.acc_in_valid  = 1'b0;
        bus.acc_out_ready = 1'b1;
        bus.acc_ovf_clr   = clr;
        @(posedge clk);
        #1;
        bus.acc_ovf_clr = 1'b0;
        if (clr) m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (snap() !== expv(1'b0) || bus.acc_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got=%h rdy=%b want=%h rdy=1",
                     snap(), bus.acc_in_ready, expv(1'b0));
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.acc_in_ready !== 1'b1 || snap() !== expv(1'b0)) begin
            failures++;
            $display("FAIL reset_release rdy=%b got=%h want rdy=1 %h",
                     bus.acc_in_ready, snap(), expv(1'b0));
        end
    endtask

    task automatic test_load_add();
        send(2'b01, 4'h5, 1'b0, 1'b0);
        checks++;
        if (snap() !== expv(1'b1) || m_acc !== 4'h5) begin
            failures++;
            $display("FAIL load5 got=%h want=%h", snap(), expv(1'b1));
        end
        send(2'b00, 4'h3, 1'b0, 1'b0);
        checks++;
        if (snap() !== expv(1'b1) || m_acc !== 4'h8) begin
            failures++;
            $display("FAIL add3 got=%h want=%h", snap(), expv(1'b1));
        end
        idle(1'b0);
        checks++;
        if (snap() !== expv(1'b0)) begin
            failures++;
            $display("FAIL drain got=%h want=%h", snap(), expv(1'b0));
        end
    endtask

    task automatic test_wrap();
        send(2'b01, 4'hF, 1'b0, 1'b0);
        send(2'b00, 4'h0, 1'b1, 1'b0);
        checks++;
        if (snap() !== expv(1'b1) || m_ovf !== 1'b1) begin
            failures++;
            $display("FAIL wrap got=%h want=%h", snap(), expv(1'b1));
        end
        send(2'b10, 4'h6, 1'b0, 1'b0);
        checks++;
        if (snap() !== expv(1'b1)) begin
            failures++;
            $display("FAIL clear_keeps_ovf got=%h want=%h",
                     snap(), expv(1'b1));
        end
    endtask

    task automatic test_reset_mid();
        send(2'b01, 4'h9, 1'b0, 1'b0);
        bus.acc_out_ready = 1'b0;
        bus.acc_in_valid  = 1'b1;
        bus.acc_in_op     = 2'b00;
        bus.acc_in_data   = 4'h2;
        #2;
        reset = 1'b1;
        #1;
        m_acc = '0; m_cout = 1'b0; m_ovf = 1'b0;
        checks++;
        if (snap() !== expv(1'b0) || bus.acc_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got=%h rdy=%b want=%h rdy=1",
                     snap(), bus.acc_in_ready, expv(1'b0));
        end
        bus.acc_in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (snap() !== expv(1'b0) || bus.acc_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_release got=%h rdy=%b want=%h",
                     snap(), bus.acc_in_ready, expv(1'b0));
        end
    endtask

    task automatic test_backpressure();
        send(2'b01, 4'h7, 1'b0, 1'b0);
        bus.acc_out_ready = 1'b0;
        bus.acc_in_valid  = 1'b1;
        bus.acc_in_op     = 2'b00;
        bus.acc_in_data   = 4'h1;
        bus.acc_in_cin    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.acc_in_ready !== 1'b0 || snap() !== expv(1'b1)) begin
                failures++;
                $display("FAIL stall%0d rdy=%b got=%h want rdy=0 %h",
                         i, bus.acc_in_ready, snap(), expv(1'b1));
            end
            @(posedge clk);
            #1;
        end
        send(2'b00, 4'h1, 1'b0, 1'b0);
        checks++;
        if (snap() !== expv(1'b1) || m_acc !== 4'h8) begin
            failures++;
            $display("FAIL b2b_1 got=%h want=%h", snap(), expv(1'b1));
        end
        send(2'b00, 4'h2, 1'b0, 1'b0);
        checks++;
        if (snap() !== expv(1'b1) || m_acc !== 4'hA) begin
            failures++;
            $display("FAIL b2b_2 got=%h want=%h", snap(), expv(1'b1));
        end
    endtask

    task automatic test_ovf_clr();
        send(2'b01, 4'hF, 1'b0, 1'b0);
        send(2'b00, 4'h1, 1'b0, 1'b1);
        checks++;
        if (bus.acc_overflow !== 1'b1 || snap() !== expv(1'b1)) begin
            failures++;
            $display("FAIL set_wins got=%h want=%h", snap(), expv(1'b1));
        end
        idle(1'b1);
        checks++;
        if (bus.acc_overflow !== 1'b0 || snap() !== expv(1'b0)) begin
            failures++;
            $display("FAIL ovf_clr got=%h want=%h", snap(), expv(1'b0));
        end
    endtask

    task automatic test_hold();
        send(2'b01, 4'hA, 1'b0, 1'b0);
        send(2'b11, 4'h5, 1'b1, 1'b0);
        checks++;
        if (snap() !== expv(1'b1) || bus.acc_out_sum !== 4'hA) begin
            failures++;
            $display("FAIL hold got=%h want=%h", snap(), expv(1'b1));
        end
    endtask

    task automatic test_random();
        logic [1:0] op;
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 9) < 6) ? 2'b00 :
                 ($urandom_range(0, 3) == 0) ? 2'b10 :
                 ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01;
            send(op, W'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0));
            checks++;
            if (snap() !== expv(1'b1)) begin
                failures++;
                $display("FAIL rand%0d op=%0d got=%h want=%h",
                         i, op, snap(), expv(1'b1));
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_acc    = '0;
        m_cout   = 1'b0;
        m_ovf    = 1'b0;
        reset    = 1'b1;
        bus.acc_in_valid  = 1'b0;
        bus.acc_in_data   = '0;
        bus.acc_in_op     = 2'b00;
        bus.acc_in_cin    = 1'b0;
        bus.acc_out_ready = 1'b1;
        bus.acc_ovf_clr   = 1'b0;
        test_reset();
        test_load_add();
        test_wrap();
        test_reset_mid();
        test_backpressure();
        test_ovf_clr();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fle_carry_chain_accumulator.md
Name: fle_carry_chain_accumulator

Overview:
- Registered accumulate stage sitting directly downstream of the fle adder primitive in the CLB physical mode.
- Chains WIDTH single-bit full-add cells into a ripple carry chain. Each cell is a-bit, b-bit, cin in; sumout, cout out.
- Holds a running sum and captures chain sumout/cout into an output buffer, with a valid/ready handshake.
- Sets a sticky overflow flag from the chain's final carry-out.
- Used as the registered consumer of adder results in fabric-level verification and soft-accumulator tiles.

Parameters:
- WIDTH, 4, number of ripple full-add cells (accumulator and data width); legal range 1..32.

Ports:
- clk  input  1  fabric clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- acc_in_valid  input  1  upstream operand valid.
- acc_in_ready  output  1  stage can accept an operand this cycle.
- acc_in_data  input  WIDTH  operand, drives the b input of every chain cell.
- acc_in_op  input  2  operation: 00 ADD, 01 LOAD, 10 CLEAR, 11 HOLD.
- acc_in_cin  input  1  carry into chain cell 0; used by ADD only.
- acc_out_valid  output  1  result buffer holds an unconsumed result.
- acc_out_ready  input  1  downstream accepts the result.
- acc_out_sum  output  WIDTH  buffered accumulator value.
- acc_out_cout  output  1  buffered carry-out of chain cell WIDTH-1 (0 for LOAD/CLEAR/HOLD).
- acc_overflow  output  1  sticky carry-out flag.
- acc_ovf_clr  input  1  synchronous clear of acc_overflow.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: acc register 0, acc_out_sum 0, acc_out_cout 0, acc_out_valid 0, acc_overflow 0. acc_in_ready is 1 one cycle after reset deasserts.
- Reset mid-transaction: an in-flight accept or buffered result is dropped, with no output glitch beyond the reset values.
- Handshake:
  - acc_in_ready = !acc_out_valid || acc_out_ready (single-entry buffer; drain and refill in the same cycle).
  - Accept = acc_in_valid && acc_in_ready.
  - acc_in_valid asserted without ready has no effect; upstream holds op/data stable.
- Chain: ripple of WIDTH full-add cells. Cell i takes a = acc[i], b = acc_in_data[i], cin = carry from cell i-1 (cell 0: acc_in_cin). Purely combinational, unsigned. The sum is WIDTH bits and wraps modulo 2^WIDTH.
- On accept, by op:
  - ADD: acc <= chain sum; buffered cout <= chain cout.
  - LOAD: acc <= acc_in_data; cout <= 0.
  - CLEAR: acc <= 0; cout <= 0.
  - HOLD: acc unchanged; cout <= 0.
- On every accept: acc_out_sum <= new acc value and acc_out_valid <= 1 (latency 1 cycle, accept edge to valid).
- No accept and acc_out_ready=1: acc_out_valid <= 0. acc_out_sum and acc_out_cout hold their last values.
- No accept and acc_out_ready=0: all outputs hold.
- FSM, two states:
  - EMPTY (acc_out_valid=0): accept -> FULL.
  - FULL: (accept) -> FULL; (acc_out_ready && !accept) -> EMPTY; otherwise stay FULL.
- acc_overflow:
  - Set on an accepted ADD whose chain cout=1.
  - Cleared on acc_ovf_clr=1.
  - Set and clear in the same cycle: set wins.
  - LOAD/CLEAR do not touch it.
- Wrap-around: ADD of all-ones + 1 gives sum 0, cout 1, overflow set.
- acc_in_op X-free requirement: illegal/unknown op never occurs; all 4 codes are defined.

Decomposition:
- Shared package fle_acc_pkg holds:
  - the op encodings ACC_OP_ADD=2'b00, ACC_OP_LOAD=2'b01, ACC_OP_CLEAR=2'b10, ACC_OP_HOLD=2'b11;
  - the FSM state encoding EMPTY/FULL;
  - the WIDTH range limits.
- One sub-module: fle_ripple_chain (parameter WIDTH). It generates WIDTH full-add cell instances and exposes sum[WIDTH-1:0] and cout. It has no state; all registers stay in the top.

Test Plan:
1. Reset: assert reset mid-cycle with acc_out_valid=1 -> all outputs 0 immediately. acc_in_ready=1 after release.
2. WIDTH=4; LOAD 4'h5, then ADD data 4'h3 cin 0, acc_out_ready=1 -> results 5 then 8. cout 0, overflow 0, each valid 1 cycle after its accept.
3. WIDTH=4; LOAD 4'hF, ADD data 4'h0 cin 1 -> sum 0, cout 1, acc_overflow=1. A following CLEAR leaves overflow at 1.
4. Backpressure: acc_out_ready=0 for 3 cycles with acc_in_valid=1 -> acc_in_ready=0, output frozen, acc unchanged. Ready high -> back-to-back accept, one result per cycle.
5. acc_ovf_clr and an overflowing ADD in the same cycle -> acc_overflow stays 1. acc_ovf_clr alone next cycle -> 0.
6. HOLD after LOAD 4'hA -> acc_out_sum 4'hA, cout 0. Random ADD/LOAD sequences match a modulo-16 reference model.
